// File: rtl/clock_divider_bank.sv
// -----------------------------------------------------------------------------
// clock_divider_bank
//   N_CH independent programmable 50%-duty clock dividers running off clk_in.
//   Each channel toggles clk_out every 'half' enabled cycles and pulses tick on
//   every rising edge of its clk_out. A new half-period is loaded into a pending
//   register and only applied at a period boundary (falling edge), when the
//   channel is stopped, or on a global sync, so outputs never produce runts.
//
// Ports:
//   clk_in   in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   enable   in   global run enable; low freezes counters and outputs
//   sync     in   re-phases all channels and applies any pending half values
//   load     in   [N_CH] per-channel reload strobe
//   half_in  in   [N_CH*CNT_W] new half-periods, channel i at [i*CNT_W +: CNT_W]
//   clk_out  out  [N_CH] divided clocks (registered)
//   tick     out  [N_CH] one-cycle pulse in the first cycle clk_out[i] is high
//   busy     out  [N_CH] reload captured but not yet applied
// -----------------------------------------------------------------------------
module clock_divider_bank #(
    parameter int unsigned N_CH     = 3,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEF_HALF = 2500
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    sync,
    input  logic [N_CH-1:0]         load,
    input  logic [N_CH*CNT_W-1:0]   half_in,
    output logic [N_CH-1:0]         clk_out,
    output logic [N_CH-1:0]         tick,
    output logic [N_CH-1:0]         busy
);

    localparam logic [CNT_W-1:0] DEF_HALF_W = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] half_q;
        logic [CNT_W-1:0] pend;
        logic             stopped;
        logic             terminal;

        assign stopped  = (half_q == '0);
        assign terminal = (cnt == half_q - ONE);

        // The load capture sits after the apply logic so that a load landing on
        // an apply point replaces pend/busy after the old pending value is used.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt        <= '0;
                half_q     <= DEF_HALF_W;
                pend       <= '0;
                clk_out[g] <= 1'b0;
                tick[g]    <= 1'b0;
                busy[g]    <= 1'b0;
            end else begin
                tick[g] <= 1'b0;
                if (sync) begin
                    cnt        <= '0;
                    clk_out[g] <= 1'b0;
                    if (busy[g]) begin
                        half_q  <= pend;
                        busy[g] <= 1'b0;
                    end
                end else if (stopped) begin
                    cnt        <= '0;
                    clk_out[g] <= 1'b0;
                    if (enable && busy[g]) begin
                        half_q  <= pend;
                        busy[g] <= 1'b0;
                    end
                end else if (enable) begin
                    if (terminal) begin
                        cnt        <= '0;
                        clk_out[g] <= ~clk_out[g];
                        tick[g]    <= ~clk_out[g];
                        // Falling edge is the only running-channel boundary.
                        if (clk_out[g] && busy[g]) begin
                            half_q  <= pend;
                            busy[g] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end

                if (load[g]) begin
                    pend    <= half_in[g*CNT_W +: CNT_W];
                    busy[g] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

    localparam int N_CH     = 3;
    localparam int CNT_W    = 16;
    localparam int DEF_HALF = 2500;

    logic                  clk_in = 1'b0;
    logic                  rst_n;
    logic                  enable;
    logic                  sync;
    logic [N_CH-1:0]       load;
    logic [N_CH*CNT_W-1:0] half_in;
    logic [N_CH-1:0]       clk_out;
    logic [N_CH-1:0]       tick;
    logic [N_CH-1:0]       busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: remaining cycles in the current level (count-down).
    int m_half [N_CH];
    int m_pend [N_CH];
    int m_rem  [N_CH];
    bit m_busy [N_CH];
    bit m_clk  [N_CH];
    bit m_tick [N_CH];

    clock_divider_bank #(
        .N_CH     (N_CH),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .enable  (enable),
        .sync    (sync),
        .load    (load),
        .half_in (half_in),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_half[i] = DEF_HALF;
            m_rem[i]  = DEF_HALF;
            m_pend[i] = 0;
            m_busy[i] = 1'b0;
            m_clk[i]  = 1'b0;
            m_tick[i] = 1'b0;
        end
    endfunction

    function automatic void model_apply(input int i);
        m_half[i] = m_pend[i];
        m_busy[i] = 1'b0;
        m_rem[i]  = m_half[i];
    endfunction

    function automatic void model_step();
        for (int i = 0; i < N_CH; i++) begin
            m_tick[i] = 1'b0;
            if (sync) begin
                if (m_busy[i]) model_apply(i);
                m_clk[i] = 1'b0;
                m_rem[i] = m_half[i];
            end else if (m_half[i] == 0) begin
                m_clk[i] = 1'b0;
                if (enable && m_busy[i]) model_apply(i);
            end else if (enable) begin
                if (m_rem[i] > 1) begin
                    m_rem[i]--;
                end else begin
                    m_rem[i] = m_half[i];
                    if (m_clk[i]) begin
                        m_clk[i] = 1'b0;
                        if (m_busy[i]) model_apply(i);
                    end else begin
                        m_clk[i]  = 1'b1;
                        m_tick[i] = 1'b1;
                    end
                end
            end
            if (load[i]) begin
                m_pend[i] = int'(half_in[i*CNT_W +: CNT_W]);
                m_busy[i] = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        logic [N_CH-1:0] ec, et, eb;
        for (int i = 0; i < N_CH; i++) begin
            ec[i] = m_clk[i];
            et[i] = m_tick[i];
            eb[i] = m_busy[i];
        end
        chk("clk_out", 64'(clk_out), 64'(ec));
        chk("tick",    64'(tick),    64'(et));
        chk("busy",    64'(busy),    64'(eb));
    endtask

    // One clock: model advances on the edge, outputs checked on the falling edge.
    task automatic step();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_half(input int ch, input int h);
        half_in[ch*CNT_W +: CNT_W] = CNT_W'(h);
        load[ch] = 1'b1;
    endtask

    task automatic wait_rise(input int ch, input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick[ch] !== 1'b1 && n < budget);
        chk($sformatf("rise_seen_ch%0d", ch), 64'(tick[ch]), 64'd1);
    endtask

    int n, r0, r1, nt;
    logic [N_CH-1:0] frozen;

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        sync    = 1'b0;
        load    = '0;
        half_in = '0;
        model_reset();
        #2;
        check_all();

        // Release and confirm default rate: first rise at 2500, period 5000.
        @(negedge clk_in);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_rise(0, 3000, n);
        chk("first_rise_cycles", 64'(n), 64'd2500);
        chk("all_in_phase", 64'(clk_out), 64'b111);
        wait_rise(0, 6000, n);
        chk("def_period", 64'(n), 64'd5000);

        // Mid low phase: reload ch1 to 4, ch2 twice (10 then 20).
        run(3500);
        set_half(1, 4);
        set_half(2, 10);
        step();
        load = '0;
        set_half(2, 20);
        step();
        load = '0;
        chk("busy_pending", 64'(busy), 64'b110);
        n = 0;
        while (busy[1] === 1'b1 && n < 6000) begin
            step();
            n++;
        end
        chk("busy1_cleared", 64'(busy[1]), 64'd0);
        wait_rise(1, 20, n);
        chk("ch1_first_rise", 64'(n), 64'd4);
        wait_rise(1, 20, n);
        chk("ch1_period", 64'(n), 64'd8);
        run(60);

        // Halves 3 and 5 pending, then sync applies and re-phases.
        set_half(0, 3);
        set_half(1, 5);
        step();
        load = '0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("sync_clk_low", 64'(clk_out), 64'd0);
        chk("sync_busy_clr", 64'(busy), 64'd0);
        r0 = 0;
        r1 = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (tick[0] === 1'b1 && r0 == 0) r0 = k;
            if (tick[1] === 1'b1 && r1 == 0) r1 = k;
        end
        chk("sync_rise_h3", 64'(r0), 64'd3);
        chk("sync_rise_h5", 64'(r1), 64'd5);

        // Stop ch0 with half=0, then restart at half=1.
        set_half(0, 0);
        step();
        load = '0;
        n = 0;
        while (busy[0] === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("stop_applied", 64'(busy[0]), 64'd0);
        run(10);
        chk("stopped_low", 64'(clk_out[0]), 64'd0);
        set_half(0, 1);
        step();
        load = '0;
        nt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (tick[0] === 1'b1) nt++;
        end
        chk("half1_ticks", 64'(nt), 64'd4);

        // Randomized traffic with small halves.
        for (int k = 0; k < 1500; k++) begin
            enable = ($urandom_range(7) != 0);
            sync   = ($urandom_range(63) == 0);
            for (int i = 0; i < N_CH; i++) begin
                load[i] = ($urandom_range(7) == 0);
                half_in[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(7));
            end
            step();
        end
        enable = 1'b1;
        sync   = 1'b0;
        load   = '0;

        // Freeze mid-high phase, then asynchronous reset while frozen.
        for (int i = 0; i < N_CH; i++) set_half(i, 6);
        step();
        load = '0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        wait_rise(0, 20, n);
        run(2);
        enable = 1'b0;
        frozen = clk_out;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("frozen_clk", 64'(clk_out), 64'(frozen));
            chk("frozen_tick", 64'(tick), 64'd0);
        end
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clk", 64'(clk_out), 64'd0);
        chk("async_tick", 64'(tick), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk_in);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_rise(0, 3000, n);
        chk("post_reset_rise", 64'(n), 64'd2500);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- N_CH independent programmable clock dividers driven from the single system clock.
- Each channel produces a 50%-duty divided clock and a one-cycle rising-edge strobe.
- Half-period is reloadable at run time. A new value takes effect glitch-free at the channel's next period boundary.
- A global sync re-phases all channels. Successor to the fixed three-rate generator; feeds sampling, UART baud and IR carrier logic.

Parameters:
- N_CH, 3, number of divider channels.
- CNT_W, 16, width of each half-period value and counter.
- DEF_HALF, 2500, half-period (in clk_in cycles) loaded into every channel at reset. 2500 gives 10 kHz from 50 MHz.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  global run enable; low freezes all channels.
- sync  input  1  synchronous pulse; re-phases all channels.
- load  input  N_CH  per-channel reload strobe.
- half_in  input  N_CH*CNT_W  per-channel new half-period. Channel i occupies bits [i*CNT_W +: CNT_W].
- clk_out  output  N_CH  divided clocks, registered.
- tick  output  N_CH  one-cycle pulse, registered.
- busy  output  N_CH  reload pending, not yet applied.

Behaviour:
- Reset (async, rst_n=0):
  - clk_out=0, tick=0, busy=0, cnt=0.
  - active half = DEF_HALF, pending cleared.
  - Outputs change immediately, without waiting for a clock edge.
- Per channel, with enable=1 and half≠0:
  - If cnt == half-1: cnt←0 and clk_out toggles. Otherwise cnt←cnt+1.
  - Output period is 2*half cycles at 50% duty. half=1 gives clk_in/2.
- tick[i]: high for exactly the one cycle in which clk_out[i] is 1 after having been 0. It is registered in the same edge as the toggle.
- half=0: channel stopped. clk_out=0, cnt held at 0, tick=0.
- Reload:
  - load[i]=1 captures half_in slice into pending[i] and sets busy[i] next cycle.
  - A second load before apply overwrites pending; last value wins.
- Apply points:
  - (a) A terminal count where clk_out[i] is currently 1, i.e. the falling edge and period boundary. Active half←pending, busy←0, cnt←0.
  - (b) Immediately next cycle if the channel is stopped.
  - Never applied mid-period, so there are no runt pulses.
- Load in the same cycle as an apply point:
  - The previously pending value, if any, is applied.
  - The new value becomes pending and busy stays 1.
  - With no previous pending, the boundary proceeds with the old half and the new value waits for the next boundary.
- Loading 0: applies at the next falling boundary. The output is then already 0, so the channel stops cleanly.
- enable=0:
  - cnt and clk_out hold, tick=0.
  - Loads are still captured. Stopped channels do not apply until enable=1.
- sync=1 (priority over counting and load-apply, all channels):
  - cnt←0, clk_out←0, tick←0.
  - Any pending value is applied immediately and busy←0.
  - A load in the same cycle as sync is captured as pending after the sync apply.
  - sync acts regardless of enable.
- Counter wrap: cnt never exceeds half-1. A reload to a smaller half is only applied at boundaries where cnt has been zeroed.
- Reset mid-operation: all state returns to reset values asynchronously; pending loads are discarded.

Test Plan:
- Reset, enable=1, N_CH=3, all channels at DEF_HALF=2500 -> clk_out[0] first rises after 2500 cycles, period 5000 cycles. tick is 1 cycle wide every 5000 cycles. All channels are in phase.
- Load ch1 half=4 while clk_out[1] is low mid-period -> busy[1]=1 until the next falling boundary, then a period of 8 cycles. There is no high or low phase shorter than 4 cycles.
- Load ch2 twice (10 then 20) before its boundary -> 20 is applied, 10 never appears, busy clears once.
- Load ch0 half=0 -> output stops low after completing its current high phase. Then load half=1 -> toggles every cycle starting the next cycle, tick every 2 cycles.
- Channels at halves 3 and 5, pulse sync -> both clk_out=0 next cycle, and both rise again exactly 3 and 5 cycles later. Pending values are applied at sync.
- enable low for 7 cycles mid-high-phase, then assert rst_n=0 asynchronously -> outputs frozen during disable, tick=0. On reset all outputs go to 0 without a clock edge, and the DEF_HALF period resumes after release.
